mult_accumulator: RTL

Frame accumulator sitting directly downstream of the array multiplier: consumes the multiplier's product stream (`o_valid` / `Z_final`) and sums FRAME_LEN consecutive valid products into one result. The multiplier has no backpressure, so this block always accepts input. It presents each completed frame sum in a single-entry result register with a valid/ready handshake toward its consumer.

---
 rtl/mult_accumulator.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mult_accumulator.sv
// mult_accumulator: sums FRAME_LEN consecutive valid products from the array
// multiplier into one frame result, presented through a single-entry result
// register with a valid/ready handshake toward the consumer.
//
// Optional feature macro: MULT_ACC_SATURATE_EN
//   defined   -> an overflowing accumulate clamps to all-ones for the rest of the frame
//   undefined -> accumulation wraps modulo 2^ACC_WIDTH
// Both builds raise o_overflow for a frame whose true sum exceeded ACC_WIDTH.
//
// Handshake: o_valid means the result register holds an unconsumed sum; a
// transfer happens on any rising edge where o_valid && o_ready. o_sum and
// o_overflow never change while o_valid && !o_ready. The input side has no
// backpressure: every i_valid cycle is consumed unless i_clear is high.
//
// fsm_state exposes the frame FSM (0 = IDLE, 1 = ACCUM) for observation.

module mult_accumulator #(
    parameter int DATAWIDTH = 4,
    parameter int ACC_WIDTH = 16,
    parameter int FRAME_LEN = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic [2*DATAWIDTH-1:0]   i_product,
    input  logic                     i_clear,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [ACC_WIDTH-1:0]     o_sum,
    output logic                     o_overflow,
    output logic                     o_overrun,
    output logic                     fsm_state
);

    localparam int CW = $clog2(FRAME_LEN + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                 state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [CW-1:0]          count;
    logic                   ovf_trk;

    logic [ACC_WIDTH:0]     sum_ext;
    logic                   ovf_step;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic                   frame_ovf_next;
    logic                   last;
    logic                   accept;
    logic                   complete;

    assign fsm_state = state;

    // Next accumulator value, overflow detection and frame-completion decode
    always_comb begin
        sum_ext        = {1'b0, acc} + (ACC_WIDTH + 1)'(i_product);
        ovf_step       = sum_ext[ACC_WIDTH];
`ifdef MULT_ACC_SATURATE_EN
        acc_next       = ovf_step ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
`else
        acc_next       = sum_ext[ACC_WIDTH-1:0];
`endif
        frame_ovf_next = ovf_trk | ovf_step;
        last           = (count == CW'(FRAME_LEN - 1));
        accept         = i_valid && !i_clear;
        complete       = accept && last;
    end

    // Frame FSM: accumulate accepted products, restart on completion or clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            count   <= '0;
            ovf_trk <= 1'b0;
        end else if (i_clear) begin
            state   <= IDLE;
            acc     <= '0;
            count   <= '0;
            ovf_trk <= 1'b0;
        end else if (accept) begin
            if (last) begin
                // Completed sum leaves through the result register; next product starts fresh
                state   <= IDLE;
                acc     <= '0;
                count   <= '0;
                ovf_trk <= 1'b0;
            end else begin
                state   <= ACCUM;
                acc     <= acc_next;
                count   <= count + CW'(1);
                ovf_trk <= frame_ovf_next;
            end
        end
    end

    // Result register: load on completion if empty or popped this cycle, else drop and flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid    <= 1'b0;
            o_sum      <= '0;
            o_overflow <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (complete) begin
                if (!o_valid || o_ready) begin
                    o_valid    <= 1'b1;
                    o_sum      <= acc_next;
                    o_overflow <= frame_ovf_next;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && o_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
